// File: rtl/score_pkg.sv
// Shared constants and state encoding for the high-score RAM scheduler.
package score_pkg;
    localparam int NUM_USERS = 6;
    localparam int ADDR_W    = 3;
    localparam int SCORE_W   = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RF_WAIT = 3'd1,
        UP_WAIT = 3'd2,
        UP_CMP  = 3'd3,
        UP_WR   = 3'd4,
        CLR_WR  = 3'd5
    } state_t;
endpackage

// File: rtl/score_shadow_bank.sv
// Registered mirror of the six stored scores feeding the display decoders.
module score_shadow_bank
    import score_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [SCORE_W-1:0] data,
    input  logic               we,
    output logic [SCORE_W-1:0] scoreUserAddr0,
    output logic [SCORE_W-1:0] scoreUserAddr1,
    output logic [SCORE_W-1:0] scoreUserAddr2,
    output logic [SCORE_W-1:0] scoreUserAddr3,
    output logic [SCORE_W-1:0] scoreUserAddr4,
    output logic [SCORE_W-1:0] scoreUserAddr5
);
    logic [SCORE_W-1:0] regs [NUM_USERS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_USERS; i++) regs[i] <= '0;
        end else if (we && addr < ADDR_W'(NUM_USERS)) begin
            regs[addr] <= data;
        end
    end

    assign scoreUserAddr0 = regs[0];
    assign scoreUserAddr1 = regs[1];
    assign scoreUserAddr2 = regs[2];
    assign scoreUserAddr3 = regs[3];
    assign scoreUserAddr4 = regs[4];
    assign scoreUserAddr5 = regs[5];
endmodule

// File: rtl/score_ram_scheduler.sv
// Arbitrates the single-port high-score RAM between clear, game-end update and
// a background refresh sweep that keeps the display shadows current.
module score_ram_scheduler #(
    parameter int RD_LAT    = 2,
    parameter int NUM_USERS = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         game_done,
    input  logic [score_pkg::ADDR_W-1:0] userID,
    input  logic [7:0]                   currentGameScore,
    input  logic                         clear_req,
    output logic [score_pkg::ADDR_W-1:0] ram_addr,
    output logic [7:0]                   ram_wdata,
    output logic                         ram_wren,
    input  logic [7:0]                   ram_q,
    output logic [7:0]                   scoreUserAddr0,
    output logic [7:0]                   scoreUserAddr1,
    output logic [7:0]                   scoreUserAddr2,
    output logic [7:0]                   scoreUserAddr3,
    output logic [7:0]                   scoreUserAddr4,
    output logic [7:0]                   scoreUserAddr5,
    output logic                         new_high_score,
    output logic                         update_done,
    output logic                         busy
);
    import score_pkg::*;

    // The address goes out in the dispatching IDLE cycle, so the wait states
    // only cover the remaining read latency.
    localparam logic [1:0]        RF_INIT   = 2'(RD_LAT - 1);
    localparam logic [1:0]        UP_INIT   = 2'((RD_LAT > 1) ? RD_LAT - 2 : 0);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_USERS - 1);

    state_t              state, state_nxt;
    logic [1:0]          cnt, cnt_nxt;
    logic [ADDR_W-1:0]   ptr, clr_idx;
    logic                upd_pend, clr_pend;
    logic [ADDR_W-1:0]   pend_user, act_user;
    logic [SCORE_W-1:0]  pend_score, act_score;
    logic                dispatch_upd, dispatch_clr, done_nxt, nhs_nxt;
    logic                sh_we;
    logic [ADDR_W-1:0]   sh_addr;
    logic [SCORE_W-1:0]  sh_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            ptr            <= '0;
            clr_idx        <= '0;
            upd_pend       <= 1'b0;
            clr_pend       <= 1'b0;
            pend_user      <= '0;
            pend_score     <= '0;
            act_user       <= '0;
            act_score      <= '0;
            update_done    <= 1'b0;
            new_high_score <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            update_done    <= done_nxt;
            new_high_score <= nhs_nxt;
            if (state == RF_WAIT && cnt == '0)
                ptr <= (ptr == LAST_ADDR) ? '0 : ptr + 1'b1;
            if (dispatch_clr)
                clr_idx <= '0;
            else if (state == CLR_WR)
                clr_idx <= clr_idx + 1'b1;
            // Pending flags drop at dispatch so a request arriving mid-operation re-arms them.
            upd_pend <= game_done | (upd_pend & ~dispatch_upd);
            clr_pend <= clear_req | (clr_pend & ~dispatch_clr);
            if (game_done) begin
                pend_user  <= userID;
                pend_score <= currentGameScore;
            end
            if (dispatch_upd) begin
                act_user  <= pend_user;
                act_score <= pend_score;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        ram_addr     = '0;
        ram_wdata    = '0;
        ram_wren     = 1'b0;
        sh_we        = 1'b0;
        sh_addr      = '0;
        sh_data      = '0;
        dispatch_upd = 1'b0;
        dispatch_clr = 1'b0;
        done_nxt     = 1'b0;
        nhs_nxt      = 1'b0;
        case (state)
            IDLE: begin
                if (clr_pend) begin
                    dispatch_clr = 1'b1;
                    state_nxt    = CLR_WR;
                end else if (upd_pend) begin
                    dispatch_upd = 1'b1;
                    if (pend_user < ADDR_W'(NUM_USERS)) begin
                        ram_addr  = pend_user;
                        cnt_nxt   = UP_INIT;
                        state_nxt = (RD_LAT > 1) ? UP_WAIT : UP_CMP;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end else begin
                    ram_addr  = ptr;
                    cnt_nxt   = RF_INIT;
                    state_nxt = RF_WAIT;
                end
            end
            RF_WAIT: begin
                ram_addr = ptr;
                if (cnt == '0) begin
                    sh_we     = 1'b1;
                    sh_addr   = ptr;
                    sh_data   = ram_q;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 2'd1;
                end
            end
            UP_WAIT: begin
                ram_addr = act_user;
                if (cnt == '0) state_nxt = UP_CMP;
                else           cnt_nxt   = cnt - 2'd1;
            end
            UP_CMP: begin
                ram_addr = act_user;
                if (act_score > ram_q) begin
                    state_nxt = UP_WR;
                end else begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            UP_WR: begin
                ram_addr  = act_user;
                ram_wdata = act_score;
                ram_wren  = 1'b1;
                sh_we     = 1'b1;
                sh_addr   = act_user;
                sh_data   = act_score;
                done_nxt  = 1'b1;
                nhs_nxt   = 1'b1;
                state_nxt = IDLE;
            end
            CLR_WR: begin
                ram_addr = clr_idx;
                ram_wren = 1'b1;
                sh_we    = 1'b1;
                sh_addr  = clr_idx;
                if (clr_idx == LAST_ADDR) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = upd_pend | clr_pend |
                  (state == UP_WAIT) | (state == UP_CMP) | (state == UP_WR) | (state == CLR_WR);

    score_shadow_bank u_shadow (
        .clk            (clk),
        .rst            (rst),
        .addr           (sh_addr),
        .data           (sh_data),
        .we             (sh_we),
        .scoreUserAddr0 (scoreUserAddr0),
        .scoreUserAddr1 (scoreUserAddr1),
        .scoreUserAddr2 (scoreUserAddr2),
        .scoreUserAddr3 (scoreUserAddr3),
        .scoreUserAddr4 (scoreUserAddr4),
        .scoreUserAddr5 (scoreUserAddr5)
    );
endmodule

// File: doc/score_ram_scheduler.md
Name: score_ram_scheduler

Overview:
- Owns the single-port high-score RAM: 6 users x 8-bit scores, at addresses 0-5.
- Shares the RAM between three requesters:
  - a background refresh sweep that mirrors all six scores into registered outputs for the hex4/hex5 score display;
  - a game-end update that writes the current game score back only if it beats the user's stored high score;
  - a clear-all request.
- Sits between the game FSM, the RAM macro and the display decoders.

Parameters:
- RD_LAT, 2, RAM read latency in cycles from address presented to ram_q valid (1..3).
- NUM_USERS, 6, number of score entries (addresses 0..NUM_USERS-1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- game_done  in  1  one-cycle pulse; current game over, request high-score update.
- userID  in  3  user being updated; sampled on game_done.
- currentGameScore  in  8  final game score; sampled on game_done.
- clear_req  in  1  one-cycle pulse; zero all stored scores.
- ram_addr  out  3  RAM address.
- ram_wdata  out  8  RAM write data.
- ram_wren  out  1  RAM write enable.
- ram_q  in  8  RAM read data, valid RD_LAT cycles after address.
- scoreUserAddr0..scoreUserAddr5  out  8 each  shadow copies of stored scores, to the display decoder.
- new_high_score  out  1  one-cycle pulse when an update wrote a higher score.
- update_done  out  1  one-cycle pulse when a game_done request completes, written or not.
- busy  out  1  high while an update or clear is pending or in progress.

Behaviour:
- Reset values (asynchronous):
  - all outputs 0, all shadows 0;
  - state IDLE, refresh pointer 0, pending flags cleared.
  - RAM contents are not touched by reset. A reset mid-write deasserts ram_wren immediately; the partial operation is abandoned.
- Request capture:
  - game_done latches upd_pend and captures userID/currentGameScore.
  - clear_req latches clr_pend.
  - A second game_done while upd_pend is set overwrites the captured values (last wins).
  - Requests arriving while their operation is executing are re-latched and run afterwards.
- Priority at each decision point (IDLE): clr_pend > upd_pend > refresh.
  - A refresh in flight completes its current entry before yielding; it never aborts mid-read.
- States:
  - IDLE: pick the next operation per priority. Refresh is always eligible.
  - RF_WAIT: ram_addr = refresh pointer, ram_wren = 0. Wait RD_LAT cycles, then capture ram_q into shadow[ptr]. Pointer increments and wraps 5 -> 0. Return to IDLE.
  - UP_WAIT: ram_addr = captured userID. After RD_LAT cycles go to UP_CMP.
  - UP_CMP: unsigned 8-bit compare.
    - captured score > ram_q (strict): go to UP_WR.
    - otherwise: pulse update_done, return to IDLE.
  - UP_WR: one cycle with ram_wren = 1 and ram_wdata = captured score.
    - shadow[userID] updated on the same edge.
    - pulse new_high_score and update_done; clear upd_pend; go to IDLE.
  - CLR_WR: six consecutive write cycles, addr 0..5, wdata 0. Shadows zeroed as written. Clear clr_pend, go to IDLE.
- Edge cases:
  - userID >= NUM_USERS: no RAM access; update_done pulses one cycle after dispatch; no new_high_score.
  - Equal score: no write.
  - Scores are packed BCD. The binary compare is valid for legal BCD; no BCD checking is done.
- Timing:
  - Refresh: RD_LAT+1 cycles per entry; full sweep 6*(RD_LAT+1) = 18 cycles at default.
  - Update latency, dispatch to update_done: RD_LAT+2 cycles with a write, RD_LAT+1 without.
  - busy = upd_pend | clr_pend | (state in UP_*/CLR_WR).

Decomposition:
- Shared package score_pkg holds:
  - NUM_USERS and ADDR_W = 3;
  - the state encoding constants (IDLE, RF_WAIT, UP_WAIT, UP_CMP, UP_WR, CLR_WR);
  - SCORE_W = 8.
- One sub-module, score_shadow_bank: six 8-bit registers with a single write port (addr, data, we), an async clear, and flat outputs scoreUserAddr0..5.
- The RAM macro stays outside this block.

Test Plan:
- Reset then idle, RAM preloaded {0x12, 0x34, 0x56, 0x78, 0x90, 0x05} -> within 18 cycles scoreUserAddr0..5 equal those values; ram_wren never asserted.
- game_done, userID=2, currentGameScore=0x60, stored 0x56 -> one ram_wren at addr 2 with wdata 0x60; scoreUserAddr2 = 0x60; new_high_score and update_done pulse together; busy drops the next cycle.
- game_done, userID=3, score=0x78 (equal to stored) -> no write, update_done pulses, new_high_score stays 0; then score 0x10 -> same result.
- clear_req and game_done in the same cycle -> clear runs first (6 writes of 0 to addr 0..5), then the update writes since score > 0; final shadows are 0 except the updated user.
- game_done with userID=7 -> no RAM access, update_done pulses, shadows unchanged.
- rst asserted during CLR_WR at addr 3 -> ram_wren = 0 asynchronously, all shadows 0; after release the refresh shows addr 0..2 = 0 and addr 3..5 = prior values.
